// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch FSM with one-entry skid; optional FETCH_ALIGN_CHECK_EN misaligned-target fault
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] skid_q;
  logic [31:0] target_pc;
  logic        halted;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_pc = redirect_pc;
  assign halted    = fetch_fault;

  // A misaligned target parks the front end until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_fault <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      fetch_fault <= 1'b1;
    end
  end
`else
  logic unused_low_bits;
  assign unused_low_bits = |redirect_pc[1:0];
  assign target_pc       = {redirect_pc[31:2], 2'b00};
  assign fetch_fault     = 1'b0;
  assign halted          = 1'b0;
`endif

  assign imem_req  = (state == S_REQ) && !halted;
  assign imem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_REQ;
      pc_q      <= RESET_PC;
      skid_q    <= 32'h0000_0000;
      valid_out <= 1'b0;
      instr_out <= NOP;
      pc_out    <= 32'h0000_0000;
    end else if (redirect) begin
      pc_q      <= target_pc;
      skid_q    <= 32'h0000_0000;
      valid_out <= 1'b0;
      // Only a still-pending response forces a detour through DROP.
      case (state)
        S_WAIT:  state <= imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state <= imem_rvalid ? S_REQ : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      if (!stall) begin
        valid_out <= 1'b0;
      end
      case (state)
        S_REQ: begin
          if (!halted) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (stall) begin
              skid_q <= imem_rdata;
              state  <= S_HOLD;
            end else begin
              instr_out <= imem_rdata;
              pc_out    <= pc_q;
              valid_out <= 1'b1;
              pc_q      <= pc_q + 32'd4;
              state     <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_out <= skid_q;
            pc_out    <= pc_q;
            valid_out <= 1'b1;
            pc_q      <= pc_q + 32'd4;
            state     <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - randomized self-checking bench for fetch against a program-order reference model
module tb_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        fetch_fault;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_valid;
  logic        w_fault;

  fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_out(instr_out),
    .pc_out(pc_out), .valid_out(valid_out), .fetch_fault(fetch_fault)
  );

  fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(32'h0000_0013), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(32'h0), .instr_out(w_instr),
    .pc_out(w_pc), .valid_out(w_valid), .fetch_fault(w_fault)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  int since = 100;
  int deliveries = 0;
  int pend_due = 0;
  bit pend = 0, junk = 1, rand_mode = 0, w_req_q = 0;
  bit reset_next = 1, stall_next = 0, redirect_next = 0;
  bit reset_prev = 1, stall_prev = 0, redirect_prev = 0;
  bit exp_valid = 0, fault_exp = 0;
  logic [31:0] pend_addr = 32'h0, next_pc = 32'h0, exp_pc = 32'h0, exp_instr = 32'h13;
  logic [31:0] rpc_next = 32'h0, rpc_prev = 32'h0;
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] wlog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle: check outputs of this cycle, then drive this cycle's inputs.
  task automatic step();
    bit deliv;
    @(negedge clk);
    cyc++;
    deliv = 0;
    if (reset_prev) begin
      exp_valid = 0; exp_pc = 32'h0; exp_instr = 32'h13; next_pc = 32'h0;
      since = 100; fault_exp = 0;
    end else if (redirect_prev) begin
      exp_valid = 0;
      since = 1;
`ifdef FETCH_ALIGN_CHECK_EN
      next_pc = rpc_prev;
      if (rpc_prev[1:0] != 2'b00) fault_exp = 1;
`else
      next_pc = {rpc_prev[31:2], 2'b00};
`endif
    end else begin
      since++;
      if (!stall_prev) begin
        if (valid_out) begin
          deliv = 1;
          check("redir_latency", {31'b0, since >= 3}, 32'd1);
          check("deliv_pc", pc_out, next_pc);
          check("deliv_instr", instr_out, mem_word(next_pc));
          exp_pc = next_pc;
          exp_instr = mem_word(next_pc);
          exp_valid = 1;
          next_pc = next_pc + 32'd4;
          deliveries++;
        end else begin
          exp_valid = 0;
        end
      end
    end
    if (!deliv) begin
      check("hold_pc", pc_out, exp_pc);
      check("hold_instr", instr_out, exp_instr);
      if (reset_prev || redirect_prev || stall_prev) check("valid", valid_out, exp_valid);
    end
    check("fault", fetch_fault, fault_exp);

    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (reset_next) pend = 0;
    if (junk) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0BAD;
    end else if (pend && pend_due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr);
      pend = 0;
    end
    if (imem_req && !reset_next) begin
      check("one_outstanding", {31'b0, pend}, 32'd0);
      pend = 1;
      pend_addr = imem_addr;
      pend_due = cyc + $urandom_range(lat_min, lat_max);
      req_log.push_back(imem_addr);
      req_cyc.push_back(cyc);
    end

    w_rvalid = w_req_q;
    if (w_req && !reset_next) wlog.push_back(w_addr);
    w_req_q = w_req && !reset_next;

    if (rand_mode) begin
      stall = ($urandom_range(0, 9) < 3);
      redirect = !imem_req && ($urandom_range(0, 19) == 0);
      redirect_pc = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFF));
`ifdef FETCH_ALIGN_CHECK_EN
      redirect_pc[1:0] = 2'b00;
`endif
    end else begin
      stall = stall_next;
      redirect = redirect_next;
      redirect_pc = rpc_next;
    end
    reset = reset_next;
    reset_prev = reset;
    stall_prev = stall;
    redirect_prev = redirect;
    rpc_prev = redirect_pc;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req) return;
    end
    check({tag, "_req_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_deliv(input logic [31:0] want, input string tag);
    int d0;
    d0 = deliveries;
    for (int i = 0; i < 12; i++) begin
      step();
      if (deliveries != d0) begin
        check(tag, pc_out, want);
        return;
      end
    end
    check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int d0;
    int rel_cyc;

    // Reset with junk responses during reset and the first cycle after.
    req_log.delete();
    reset_next = 1; junk = 1;
    step(); step(); step();
    reset_next = 0;
    step();
    rel_cyc = cyc;
    junk = 0;

    // Straight-line fetch with 1-cycle memory.
    for (int i = 0; i < 6; i++) step();
    if (req_log.size() >= 3) begin
      check("a_addr0", req_log[0], 32'h0);
      check("a_addr1", req_log[1], 32'h4);
      check("a_addr2", req_log[2], 32'h8);
      check("a_first_req_cyc", req_cyc[0], rel_cyc);
      check("a_req_spacing", req_cyc[1] - req_cyc[0], 32'd2);
    end else begin
      check("a_req_count", req_log.size(), 32'd3);
    end
    d0 = deliveries;
    for (int i = 0; i < 20; i++) step();
    check("a_throughput", deliveries - d0, 32'd10);

    // Stall across the response: skid holds it, released exactly once.
    wait_req("b");
    stall_next = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("b_noreq", imem_req, 1'b0);
    end
    stall_next = 0;
    d0 = deliveries;
    step();
    step();
    check("b_one_deliv", deliveries - d0, 32'd1);
    step();
    check("b_no_dup", deliveries - d0, 32'd1);

    // Redirect in WAIT, stale response two cycles after the request.
    lat_min = 2; lat_max = 2;
    wait_req("c");
    redirect_next = 1; rpc_next = 32'h0000_0100;
    step();
    redirect_next = 0;
    step();
    check("c_drop_noreq", imem_req, 1'b0);
    step();
    check("c_req", imem_req, 1'b1);
    check("c_addr", imem_addr, 32'h0000_0100);
    wait_deliv(32'h0000_0100, "c_deliv");

    // Redirect in the same cycle as the response.
    lat_min = 1; lat_max = 1;
    wait_req("d");
    redirect_next = 1; rpc_next = 32'h0000_0200;
    step();
    redirect_next = 0;
    step();
    check("d_req", imem_req, 1'b1);
    check("d_addr", imem_addr, 32'h0000_0200);
    wait_deliv(32'h0000_0200, "d_deliv");

    // Random stall, redirect and memory latency.
    lat_min = 1; lat_max = 3;
    rand_mode = 1;
    d0 = deliveries;
    for (int i = 0; i < 1500; i++) step();
    rand_mode = 0;
    stall_next = 0;
    check("r_progress", {31'b0, (deliveries - d0) > 100}, 32'd1);
    for (int i = 0; i < 6; i++) step();

    // Misaligned redirect target.
    lat_min = 1; lat_max = 1;
    wait_req("e");
    redirect_next = 1; rpc_next = 32'h0000_0102;
    step();
    redirect_next = 0;
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    check("e_fault", fetch_fault, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("e_noreq", imem_req, 1'b0);
      step();
    end
`else
    check("e_req", imem_req, 1'b1);
    check("e_addr", imem_addr, 32'h0000_0100);
    check("e_nofault", fetch_fault, 1'b0);
`endif

    // Wrap-around from RESET_PC = 0xFFFF_FFFC.
    if (wlog.size() >= 2) begin
      check("w_addr0", wlog[0], 32'hFFFF_FFFC);
      check("w_addr1", wlog[1], 32'h0000_0000);
    end else begin
      check("w_req_count", wlog.size(), 32'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
